spart_driver: RTL and testbench

//  Processor-side bus master for the spart peripheral; sits beside it in the top level on the shared

---
 rtl/spart_driver_if.sv | 22 ++
 rtl/spart_driver.sv | 198 +++++++++++++++++++
 tb/tb_spart_driver.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spart_driver_if.sv
// rtl/spart_driver_if.sv - spart processor-side handshake/bus interface
//
// Purpose: groups the chip-select, direction, address and status handshake
// between spart_driver (master) and the spart peripheral (slave). The 8-bit
// tristate databus stays a plain inout on the driver so it resolves at top level.
//
// Signals:
//   iocs    chip select to spart
//   iorw    1 = read, 0 = write
//   ioaddr  00 = tx/rx data, 01 = status, 10 = divisor low, 11 = divisor high
//   rda     receive data available (single-cycle pulse from spart)
//   tbr     transmit buffer ready from spart (1 = may write)
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_driver.sv
// rtl/spart_driver.sv - processor-side echo master for the spart peripheral
//
// Purpose: after reset, programs the baud divisor selected by br_cfg (low byte
// then high byte), then echoes every received byte: capture on rda, wait for
// tbr, write it back to the data register.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   br_cfg    baud select: 00=4800 01=9600 10=19200 11=38400
//   bus       spart_driver_if master modport (iocs, iorw, ioaddr, rda, tbr)
//   databus   8-bit tristate data bus, driven only while iocs && !iorw
//   last_rx   most recently captured byte
//   ovr       sticky flag: a received byte was dropped; cleared only by rst
//
// Build option: define SPART_DRV_BUF_EN to place a 4-entry byte FIFO between
// capture and transmit.
module spart_driver #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     br_cfg,
  spart_driver_if.master bus,
  inout  wire  [7:0]     databus,
  output logic [7:0]     last_rx,
  output logic           ovr
);

  localparam logic [2:0] S_CFG_LO   = 3'd0;
  localparam logic [2:0] S_CFG_HI   = 3'd1;
  localparam logic [2:0] S_IDLE     = 3'd2;
  localparam logic [2:0] S_WAIT_TBR = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_HOLD     = 3'd5;

  localparam logic [15:0] DB_4800  = 16'(CLK_FREQ_HZ / 32'd4800  - 32'd1);
  localparam logic [15:0] DB_9600  = 16'(CLK_FREQ_HZ / 32'd9600  - 32'd1);
  localparam logic [15:0] DB_19200 = 16'(CLK_FREQ_HZ / 32'd19200 - 32'd1);
  localparam logic [15:0] DB_38400 = 16'(CLK_FREQ_HZ / 32'd38400 - 32'd1);

  logic [2:0]  state_q, state_d;
  // Low only in the cycle right after reset, so the bus stays idle there and
  // the drive enable never depends combinationally on rst.
  logic        active_q, active_d;
  logic [1:0]  cfg_q, cfg_d;
  logic [7:0]  last_rx_q, last_rx_d;
  logic        ovr_q, ovr_d;

  logic [15:0] db;
  logic        drive_en;
  logic        rx_ok;
  logic        rx_take;
  logic        has_data;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic [7:0]  dout;

`ifdef SPART_DRV_BUF_EN
  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic [7:0] tx_q, tx_d;
  logic       push;
  logic       pop;

  assign rx_ok    = !(state_q == S_CFG_LO || state_q == S_CFG_HI || state_q == S_WRITE);
  // The pop happens on the WAIT_TBR -> WRITE edge, so a push in that same
  // cycle can reuse the slot being freed.
  assign pop      = (state_q == S_WAIT_TBR) && bus.tbr && (count_q != 3'd0);
  assign push     = bus.rda && rx_ok && ((count_q != 3'd4) || pop);
  assign rx_take  = push;
  assign has_data = (count_q != 3'd0);
  assign tx_ready = (count_q != 3'd0);
  assign tx_byte  = tx_q;
`else
  assign rx_ok    = (state_q == S_IDLE);
  assign rx_take  = bus.rda && rx_ok;
  assign has_data = 1'b0;
  assign tx_ready = 1'b1;
  assign tx_byte  = last_rx_q;
`endif

  always_comb begin
    case (cfg_q)
      2'b00:   db = DB_4800;
      2'b01:   db = DB_9600;
      2'b10:   db = DB_19200;
      default: db = DB_38400;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    active_d  = 1'b1;
    cfg_d     = cfg_q;
    last_rx_d = last_rx_q;
    ovr_d     = ovr_q;

    case (state_q)
      S_CFG_LO:   if (active_q) state_d = S_CFG_HI;
      S_CFG_HI:   state_d = S_IDLE;
      // A byte arriving (or already queued) wins over a baud change.
      S_IDLE:     if (rx_take || has_data) state_d = S_WAIT_TBR;
                  else if (br_cfg != cfg_q) state_d = S_CFG_LO;
      S_WAIT_TBR: if (bus.tbr && tx_ready) state_d = S_WRITE;
      S_WRITE:    state_d = S_HOLD;
      // spart drops tbr one edge after the write, so tbr is not trusted here.
      S_HOLD:     state_d = S_IDLE;
      default:    state_d = S_CFG_LO;
    endcase

    // Keep cfg_q tracking br_cfg until CFG_LO actually drives, so the
    // divisor is stable across both configuration writes.
    if (state_d == S_CFG_LO) cfg_d = br_cfg;

    if (rx_take) last_rx_d = databus;
    if (bus.rda && !rx_take) ovr_d = 1'b1;
  end

`ifdef SPART_DRV_BUF_EN
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tx_d     = tx_q;
    if (push) begin
      mem_d[wr_ptr_q] = databus;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      tx_d     = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    count_d = count_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      tx_q     <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tx_q     <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CFG_LO;
      active_q  <= 1'b0;
      cfg_q     <= br_cfg;
      last_rx_q <= 8'h00;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      cfg_q     <= cfg_d;
      last_rx_q <= last_rx_d;
      ovr_q     <= ovr_d;
    end
  end

  assign drive_en = active_q &&
                    (state_q == S_CFG_LO || state_q == S_CFG_HI || state_q == S_WRITE);

  always_comb begin
    bus.ioaddr = 2'b00;
    dout       = tx_byte;
    if (active_q && state_q == S_CFG_LO) begin
      bus.ioaddr = 2'b10;
      dout       = db[7:0];
    end else if (state_q == S_CFG_HI) begin
      bus.ioaddr = 2'b11;
      dout       = db[15:8];
    end
  end

  // Chip select also rises combinationally in a capture cycle so spart
  // drives the received byte onto the bus before the capturing edge.
  assign bus.iocs = drive_en || (bus.rda && rx_ok);
  assign bus.iorw = !drive_en;
  assign databus  = drive_en ? dout : 8'bz;
  assign last_rx  = last_rx_q;
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_spart_driver.sv
// tb/tb_spart_driver.sv - scoreboard bench for spart_driver
module tb_spart_driver;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic [7:0] sp_rx = 8'h00;
  wire  [7:0] databus;
  logic [7:0] last_rx;
  logic       ovr;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  exp_t       exp_q[$];

  spart_driver_if bus();

  spart_driver #(.CLK_FREQ_HZ(50_000_000)) dut (
    .clk     (clk),
    .rst     (rst),
    .br_cfg  (br_cfg),
    .bus     (bus),
    .databus (databus),
    .last_rx (last_rx),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // spart side: answers a read of the data register with the received byte
  assign databus = (bus.iocs && bus.iorw) ? sp_rx : 8'bz;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [1:0] a, input logic [7:0] d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic pulse_rda(input logic [7:0] b, input logic want_cs);
    bus.rda = 1'b1;
    sp_rx   = b;
    #1;
    if (want_cs) check("iocs in rda cycle", {15'd0, bus.iocs}, 16'd1);
    tick();
    bus.rda = 1'b0;
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, " iocs"},    {15'd0, bus.iocs},   16'd0);
    check({tag, " iorw"},    {15'd0, bus.iorw},   16'd1);
    check({tag, " ioaddr"},  {14'd0, bus.ioaddr}, 16'd0);
    check({tag, " databus"}, {8'h00, databus},    16'h00zz);
  endtask

  // Monitor: every write cycle on the bus must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.iocs === 1'b1 && bus.iorw === 1'b0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected write: addr %b data %h at cycle %0d", bus.ioaddr, databus, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.ioaddr !== e.addr || databus !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
          n_err++;
          $display("FAIL bus write: got addr %b data %h cycle %0d expected addr %b data %h cycle %0d",
                   bus.ioaddr, databus, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    int c;
    bus.rda = 1'b0;
    bus.tbr = 1'b0;

    // T1: reset state, then divisor programming for 9600
    rst = 1'b1;
    repeat (3) tick();
    check_idle_bus("reset");
    check("reset last_rx", {8'h00, last_rx}, 16'h0000);
    check("reset ovr", {15'd0, ovr}, 16'd0);
    rst = 1'b0;
    expect_wr(2'b10, 8'h57, cyc + 1);
    expect_wr(2'b11, 8'h14, cyc + 2);
    repeat (3) tick();
    check_idle_bus("idle");

    // T2: echo with tbr already high, write two cycles after the rda cycle
    bus.tbr = 1'b1;
    c = cyc;
    expect_wr(2'b00, 8'hA5, c + 2);
    pulse_rda(8'hA5, 1'b1);
    check("T2 last_rx", {8'h00, last_rx}, 16'h00A5);
    repeat (4) tick();

    // T3: long tbr stall, write exactly one cycle after tbr rises
    bus.tbr = 1'b0;
    pulse_rda(8'h3C, 1'b1);
    repeat (200) tick();
    bus.tbr = 1'b1;
    expect_wr(2'b00, 8'h3C, cyc + 1);
    repeat (4) tick();
    check("T3 last_rx", {8'h00, last_rx}, 16'h003C);

    // T4: second byte arrives while waiting for tbr
    bus.tbr = 1'b0;
    pulse_rda(8'h96, 1'b1);
    tick();
`ifdef SPART_DRV_BUF_EN
    pulse_rda(8'h77, 1'b1);
    check("T4 ovr", {15'd0, ovr}, 16'd0);
    check("T4 last_rx", {8'h00, last_rx}, 16'h0077);
    repeat (3) tick();
    bus.tbr = 1'b1;
    expect_wr(2'b00, 8'h96, cyc + 1);
    expect_wr(2'b00, 8'h77, cyc + 5);
    repeat (9) tick();
`else
    pulse_rda(8'h77, 1'b0);
    check("T4 ovr", {15'd0, ovr}, 16'd1);
    check("T4 last_rx", {8'h00, last_rx}, 16'h0096);
    repeat (3) tick();
    bus.tbr = 1'b1;
    expect_wr(2'b00, 8'h96, cyc + 1);
    repeat (5) tick();
`endif

    // T5: baud change 01->11 together with an rda; the byte is echoed first
    c = cyc;
    br_cfg = 2'b11;
    expect_wr(2'b00, 8'h5A, c + 2);
    expect_wr(2'b10, 8'h15, c + 5);
    expect_wr(2'b11, 8'h05, c + 6);
    pulse_rda(8'h5A, 1'b1);
    repeat (7) tick();
    check_idle_bus("T5 idle");
`ifdef SPART_DRV_BUF_EN
    check("T5 ovr", {15'd0, ovr}, 16'd0);
`else
    check("T5 ovr sticky", {15'd0, ovr}, 16'd1);
`endif

    // T6: reset pulse in the write cycle releases the bus and restarts config
    c = cyc;
    expect_wr(2'b00, 8'hC3, c + 2);
    pulse_rda(8'hC3, 1'b1);
    tick();
    check("T6 write data", {8'h00, databus}, 16'h00C3);
    rst = 1'b1;
    tick();
    check_idle_bus("T6 reset");
    check("T6 ovr", {15'd0, ovr}, 16'd0);
    check("T6 last_rx", {8'h00, last_rx}, 16'h0000);
    rst = 1'b0;
    expect_wr(2'b10, 8'h15, cyc + 1);
    expect_wr(2'b11, 8'h05, cyc + 2);
    repeat (5) tick();
    check_idle_bus("T6 idle");

    check("scoreboard drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
